// File: rtl/common_types_pkg.sv
// Shared types and constants for the RAM dump controller.
// The HDR state only exists when RAM_DUMP_HEADER_EN is defined.
package common_types_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        READ,
        SEND,
        NEXT,
        DONE
`ifdef RAM_DUMP_HEADER_EN
        , HDR
`endif
    } dump_state_t;

    // Sent low byte first, so the wire order is A5 then 5A.
    localparam logic [15:0] RAM_DUMP_SYNC = 16'h5AA5;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/ram_dump_if.sv
// RAM read port shared between the CPU and the dump controller.
interface ram_dump_if;
    logic        override_ctrl;
    logic [31:0] ram_addr;
    logic        ram_ren;
    logic [31:0] ram_rdata;
    logic        ram_ready;

    modport master (
        output override_ctrl, ram_addr, ram_ren,
        input  ram_rdata, ram_ready
    );

    modport slave (
        input  override_ctrl, ram_addr, ram_ren,
        output ram_rdata, ram_ready
    );
endinterface

// File: rtl/ram_dump_ctrl_uart_tx_byte.sv
// 8N1 UART byte transmitter; each bit lasts BAUD_DIV clocks, line idles high.
module uart_tx_byte #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       txd
);
    localparam int unsigned CW = $clog2(BAUD_DIV + 1);

    logic          active;
    logic [8:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] baud_cnt;
    logic          bit_end;
    logic          frame_end;

    assign bit_end   = (baud_cnt == CW'(BAUD_DIV - 1));
    assign frame_end = active && bit_end && (bit_cnt == 4'd9);
    // Free during the last stop-bit clock so a queued byte follows with no idle gap.
    assign busy      = active && !frame_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            txd      <= 1'b1;
            shreg    <= 9'h1FF;
            bit_cnt  <= 4'd0;
            baud_cnt <= '0;
        end else if (start && !busy) begin
            active   <= 1'b1;
            txd      <= 1'b0;
            shreg    <= {1'b1, data};
            bit_cnt  <= 4'd0;
            baud_cnt <= '0;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                    txd    <= 1'b1;
                end else begin
                    txd     <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/ram_dump_ctrl.sv
// On a halt rising edge, reads DUMP_WORDS words from RAM and streams them little-endian over UART.
// Define RAM_DUMP_HEADER_EN to prefix the stream with A5 5A and the 16-bit word count.
module ram_dump_ctrl
    import common_types_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned DUMP_WORDS = 1024,
    parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           halt,
    ram_dump_if.master     bus,
    output logic           txd,
    output logic           busy,
    output logic           dump_done
);
    localparam int unsigned IW = $clog2(DUMP_WORDS + 1);
`ifdef RAM_DUMP_HEADER_EN
    localparam logic [31:0] HDR_WORD = {16'(DUMP_WORDS), RAM_DUMP_SYNC};
`endif

    dump_state_t   state;
    logic          halt_q;
    logic          halt_low_seen;
    logic [IW-1:0] index;
    logic [2:0]    sent;
    logic [31:0]   word;
    logic          sending;
    logic          tx_start;
    logic          tx_busy;
    logic [7:0]    tx_data;

`ifdef RAM_DUMP_HEADER_EN
    assign sending = (state == SEND) || (state == HDR);
`else
    assign sending = (state == SEND);
`endif
    assign tx_start = sending && !tx_busy && !sent[2];

    always_comb begin
        tx_data = word[8*sent[1:0] +: 8];
`ifdef RAM_DUMP_HEADER_EN
        if (state == HDR) tx_data = HDR_WORD[8*sent[1:0] +: 8];
`endif
    end

    always_ff @(posedge clk)
        if (state == READ && bus.ram_ready) word <= bus.ram_rdata;

    // halt_q clears in reset, so a halt held high through reset must be seen low once before it can arm.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            bus.override_ctrl <= 1'b0;
            bus.ram_ren       <= 1'b0;
            bus.ram_addr      <= 32'h0;
            busy              <= 1'b0;
            dump_done         <= 1'b0;
            halt_q            <= 1'b0;
            halt_low_seen     <= 1'b0;
            index             <= '0;
            sent              <= 3'd0;
        end else begin
            halt_q <= halt;
            if (!halt) halt_low_seen <= 1'b1;
            case (state)
                IDLE: if (halt && !halt_q && halt_low_seen) begin
                    state             <= ARM;
                    bus.override_ctrl <= 1'b1;
                    busy              <= 1'b1;
                    index             <= '0;
                    sent              <= 3'd0;
                end
                ARM: begin
`ifdef RAM_DUMP_HEADER_EN
                    state <= HDR;
`else
                    state        <= READ;
                    bus.ram_ren  <= 1'b1;
                    bus.ram_addr <= word_addr(START_ADDR, 32'(index));
`endif
                end
`ifdef RAM_DUMP_HEADER_EN
                HDR: begin
                    if (tx_start) begin
                        sent <= sent + 3'd1;
                    end else if (sent[2] && !tx_busy) begin
                        sent         <= 3'd0;
                        state        <= READ;
                        bus.ram_ren  <= 1'b1;
                        bus.ram_addr <= word_addr(START_ADDR, 32'(index));
                    end
                end
`endif
                READ: if (bus.ram_ready) begin
                    bus.ram_ren <= 1'b0;
                    sent        <= 3'd0;
                    state       <= SEND;
                end
                SEND: begin
                    if (tx_start) begin
                        sent <= sent + 3'd1;
                    end else if (sent[2] && !tx_busy) begin
                        sent  <= 3'd0;
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    index <= index + IW'(1);
                    if (index == IW'(DUMP_WORDS - 1)) begin
                        state             <= DONE;
                        bus.override_ctrl <= 1'b0;
                        busy              <= 1'b0;
                        dump_done         <= 1'b1;
                    end else begin
                        state        <= READ;
                        bus.ram_ren  <= 1'b1;
                        bus.ram_addr <= word_addr(START_ADDR, 32'(index) + 32'd1);
                    end
                end
                DONE: if (!halt) begin
                    state     <= IDLE;
                    dump_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (tx_start),
        .data  (tx_data),
        .busy  (tx_busy),
        .txd   (txd)
    );
endmodule

// File: tb/tb_ram_dump_ctrl.sv
// Scoreboard bench for ram_dump_ctrl: RAM responder, UART receiver and directed/random dumps.
module tb_ram_dump_ctrl;
    localparam int unsigned BAUD_DIV   = 4;
    localparam int unsigned DUMP_WORDS = 2;
    localparam logic [31:0] START_ADDR = 32'h100;
`ifdef RAM_DUMP_HEADER_EN
    localparam int HDR_BYTES = 4;
`else
    localparam int HDR_BYTES = 0;
`endif
    localparam int TOTAL_BYTES = HDR_BYTES + 4 * DUMP_WORDS;

    typedef struct {
        logic [7:0] b;
        bit         chained;
    } exp_t;

    logic clk;
    logic rst;
    logic halt;
    logic txd;
    logic busy;
    logic dump_done;

    ram_dump_if bus ();

    ram_dump_ctrl #(
        .BAUD_DIV   (BAUD_DIV),
        .DUMP_WORDS (DUMP_WORDS),
        .START_ADDR (START_ADDR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .bus       (bus),
        .txd       (txd),
        .busy      (busy),
        .dump_done (dump_done)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rst_events  = 0;
    int rx_cnt      = 0;
    int stall_idx   = -1;
    int stall_len   = 0;
    int max_lat     = 1;
    exp_t exp_q[$];
    logic [31:0] mem [logic [31:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rst_events <= rst_events + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic fill_random();
        for (int w = 0; w < DUMP_WORDS; w++) mem[START_ADDR + 32'(4 * w)] = $urandom;
    endtask

    // Reference stream: optional header, then each word low byte first.
    task automatic push_expected();
        exp_t e;
        logic [31:0] v;
`ifdef RAM_DUMP_HEADER_EN
        v = {8'(DUMP_WORDS >> 8), 8'(DUMP_WORDS), 8'h5A, 8'hA5};
        for (int k = 0; k < 4; k++) begin
            e.b = v[8*k +: 8];
            e.chained = (k != 0);
            exp_q.push_back(e);
        end
`endif
        for (int w = 0; w < DUMP_WORDS; w++) begin
            v = mem_read(START_ADDR + 32'(4 * w));
            for (int k = 0; k < 4; k++) begin
                e.b = v[8*k +: 8];
                e.chained = (k != 0);
                exp_q.push_back(e);
            end
        end
    endtask

    // RAM responder: ready after a per-read latency; watches the port while a long stall is in progress.
    initial begin : ram_model
        int rd_idx;
        int wait_cnt;
        int cur_lat;
        bit in_read;
        logic [31:0] exp_addr;
        rd_idx = 0; wait_cnt = 0; cur_lat = 1; in_read = 0;
        bus.ram_ready = 1'b0;
        bus.ram_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus.ram_ready = 1'b0;
            if (rst || !bus.override_ctrl) begin
                rd_idx = 0;
                in_read = 0;
            end else if (bus.ram_ren || in_read) begin
                exp_addr = START_ADDR + 32'(4 * rd_idx);
                if (!in_read) begin
                    in_read = 1;
                    wait_cnt = 0;
                    cur_lat = (rd_idx == stall_idx) ? stall_len : int'($urandom_range(1, max_lat));
                end
                wait_cnt++;
                if (cur_lat >= 10 && wait_cnt <= cur_lat) begin
                    check("stall_ren", 32'(bus.ram_ren), 32'd1);
                    check("stall_addr", bus.ram_addr, exp_addr);
                    check("stall_txd", 32'(txd), 32'd1);
                end
                if (wait_cnt > cur_lat) begin
                    check("read_addr", bus.ram_addr, exp_addr);
                    check("read_override", 32'(bus.override_ctrl), 32'd1);
                    check("read_busy", 32'(busy), 32'd1);
                    bus.ram_ready = 1'b1;
                    bus.ram_rdata = mem_read(bus.ram_addr);
                    rd_idx++;
                    in_read = 0;
                end
            end
        end
    end

    // UART receiver: mid-bit sampling, pops the scoreboard per completed frame.
    initial begin : uart_rx
        logic [7:0] b;
        logic startb;
        logic stopb;
        int st;
        int prev_st;
        int rst_mark;
        bit prev_ok;
        exp_t e;
        prev_ok = 0; prev_st = 0;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                st = cyc;
                rst_mark = rst_events;
                repeat (BAUD_DIV / 2) @(negedge clk);
                startb = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD_DIV) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BAUD_DIV) @(negedge clk);
                stopb = txd;
                if (rst_events != rst_mark) begin
                    prev_ok = 0;
                end else begin
                    rx_cnt++;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rx_unexpected: got byte %h, expected no byte", b);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", 32'(b), 32'(e.b));
                        check("start_bit", 32'(startb), 32'd0);
                        check("stop_bit", 32'(stopb), 32'd1);
                        if (e.chained && prev_ok)
                            check("byte_gap", 32'(st - prev_st), 32'(10 * BAUD_DIV));
                    end
                    prev_ok = 1;
                    prev_st = st;
                end
            end
        end
    end

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (dump_done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL dump_timeout: got dump_done 0, expected 1 within 4000 cycles");
        end
    endtask

    task automatic wait_rx(input int target);
        bit ok;
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (rx_cnt >= target) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_timeout: got %0d bytes, expected %0d", rx_cnt, target);
        end
    endtask

    task automatic launch();
        halt = 1'b0;
        repeat (2) @(negedge clk);
        push_expected();
        halt = 1'b1;
    endtask

    task automatic done_checks();
        check("done_flag", 32'(dump_done), 32'd1);
        check("done_override", 32'(bus.override_ctrl), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_txd", 32'(txd), 32'd1);
        check("done_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_dump();
        bit ok;
        launch();
        wait_done(ok);
        if (ok) done_checks();
        halt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_done", 32'(dump_done), 32'd0);
    endtask

    initial begin : stimulus
        bit ok;
        int base;
        int hi;
        rst = 1'b1;
        halt = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_override", 32'(bus.override_ctrl), 32'd0);
        check("rst_ren", 32'(bus.ram_ren), 32'd0);
        check("rst_addr", bus.ram_addr, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(dump_done), 32'd0);

        // halt already high when reset releases
        rst = 1'b0;
        base = rx_cnt;
        repeat (30) @(negedge clk);
        check("held_halt_override", 32'(bus.override_ctrl), 32'd0);
        check("held_halt_busy", 32'(busy), 32'd0);
        check("held_halt_bytes", 32'(rx_cnt - base), 32'd0);

        mem[32'h100] = 32'h1122_3344;
        mem[32'h104] = 32'hAABB_CCDD;
        run_dump();

        // long stall on the second read
        fill_random();
        stall_idx = 1;
        stall_len = 50;
        run_dump();
        stall_idx = -1;

        // halt drops while the second word is going out
        fill_random();
        max_lat = 3;
        base = rx_cnt;
        launch();
        wait_rx(base + HDR_BYTES + 5);
        halt = 1'b0;
        check("halt_drop_still_busy", 32'(busy), 32'd1);
        wait_done(ok);
        if (ok) begin
            done_checks();
            hi = 1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (!dump_done) break;
                hi++;
            end
            check("done_one_cycle", 32'(hi), 32'd1);
        end

        // reset in the middle of the third byte
        fill_random();
        base = rx_cnt;
        launch();
        wait_rx(base + 2);
        repeat (8) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_txd", 32'(txd), 32'd1);
        check("abort_override", 32'(bus.override_ctrl), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ren", 32'(bus.ram_ren), 32'd0);
        rst = 1'b0;
        check("abort_remaining", 32'(exp_q.size()), 32'(TOTAL_BYTES - 2));
        exp_q.delete();
        repeat (60) @(negedge clk);
        check("abort_no_restart", 32'(busy), 32'd0);
        fill_random();
        run_dump();

        for (int n = 0; n < 4; n++) begin
            fill_random();
            max_lat = int'($urandom_range(1, 6));
            run_dump();
        end

        repeat (20) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ram_dump_ctrl.md
RAM_DUMP_CTRL -- requirements
Module: ram_dump_ctrl

Interface
REQ-001 Parameter BAUD_DIV, default 434, clk cycles per UART bit (50 MHz / 115200).
REQ-002 Parameter DUMP_WORDS, default 1024, number of 32-bit words dumped.
REQ-003 Parameter START_ADDR, default 32'h0000_0000, byte address of first word.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 halt  in  1  CPU halted; a rising edge starts a dump.
REQ-007 override_ctrl  out  1  dump owns RAM port; drives ram_dump_if.override_ctrl.
REQ-008 ram_addr  out  32  word-aligned read byte address.
REQ-009 ram_ren  out  1  read request, held until ram_ready.
REQ-010 ram_rdata  in  32  read data, valid only when ram_ready=1.
REQ-011 ram_ready  in  1  read-complete strobe.
REQ-012 txd  out  1  UART serial out, 8N1, idle high.
REQ-013 busy  out  1  high from leaving IDLE until entering DONE.
REQ-014 dump_done  out  1  high while in DONE.

Function
REQ-015 FSM states IDLE, ARM, READ, SEND, NEXT, DONE; SHALL be a single enumerated state register.
REQ-016 IDLE->ARM on halt=1 with registered halt_q=0 (rising edge); level-high halt out of reset SHALL NOT start a dump.
REQ-017 ARM: override_ctrl=1, ram_ren=0, exactly one cycle, then READ (bus-turnaround cycle).
REQ-018 READ: ram_ren=1, ram_addr=START_ADDR+4*index; on ram_ready=1 capture ram_rdata, drop ram_ren next cycle, go SEND; unbounded ram_ready stall SHALL be tolerated.
REQ-019 SEND: transmit captured word as 4 bytes, little-endian (bits 7:0 first); next byte SHALL start the cycle after previous stop bit ends.
REQ-020 Byte frame: start 0, 8 data LSB first, stop 1, each bit exactly BAUD_DIV cycles; 10*BAUD_DIV cycles per byte.
REQ-021 NEXT: index+1; index==DUMP_WORDS-1 before increment -> DONE, else READ; index width $clog2(DUMP_WORDS+1).
REQ-022 Address SHALL wrap modulo 2^32; no error flagged.
REQ-023 DONE: override_ctrl=0, dump_done=1, txd=1; DONE->IDLE when halt=0.
REQ-024 halt deasserting mid-dump SHALL NOT abort; dump completes, then DONE exits next cycle.
REQ-025 override_ctrl SHALL be 1 in ARM, READ, SEND, NEXT only.
REQ-026 halt edge while not IDLE SHALL be ignored.

Reset
REQ-027 On rst: state=IDLE, override_ctrl=0, ram_ren=0, ram_addr=0, txd=1, busy=0, dump_done=0, halt_q=0, index=0, baud counter=0.
REQ-028 rst mid-dump SHALL abort immediately; txd returns high next cycle, possibly truncating a frame.

Configuration
REQ-029 Macro RAM_DUMP_HEADER_EN: when defined, ARM->HDR state sends 0xA5, 0x5A, DUMP_WORDS[7:0], DUMP_WORDS[15:8], then READ; busy covers HDR.
REQ-030 Without RAM_DUMP_HEADER_EN: no HDR state; data bytes only.

Structure
REQ-031 common_types_pkg SHALL hold dump_state_t enum and constant RAM_DUMP_SYNC = 16'h5AA5.
REQ-032 Sub-module uart_tx_byte (clk, rst, start, data[7:0], busy, txd; parameter BAUD_DIV) SHALL implement REQ-020; start ignored while busy.

Verification (BAUD_DIV=4, DUMP_WORDS=2, START_ADDR=32'h100)
REQ-033 RAM 0x100=32'h11223344, 0x104=32'hAABBCCDD, ready 1 cycle after ren; halt 0->1 -> txd bytes 44 33 22 11 DD CC BB AA, 40 cycles each; dump_done=1.
REQ-034 ram_ready stalled 50 cycles on second read -> ram_ren held, ram_addr=0x104 stable, txd idle high, output bytes unchanged.
REQ-035 halt=1 at rst release -> no dump, override_ctrl=0; halt 1->0->1 -> dump starts.
REQ-036 halt dropped during second word -> all 8 bytes sent, DONE one cycle, then IDLE.
REQ-037 rst asserted during byte 3 -> next cycle txd=1, override_ctrl=0, state IDLE; new halt edge restarts at 0x100.
REQ-038 With RAM_DUMP_HEADER_EN -> A5 5A 02 00 precede data bytes.
